// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first, one bit per clock) with start/ready and valid/ack handshakes.
// Optional macro SERIAL_SUBTRACTOR_ADD_EN adds an op port selecting add (1) or subtract (0).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT             r_state;
    stateT             w_stateNext;

    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-2:0]  r_res;
    logic              r_br;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_aMsb;
    logic              r_bMsb;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic              r_zero;
    logic              r_ovf;
    logic              r_isAdd;

    logic              w_dBit;
    logic              w_brNext;
    logic [WIDTH-1:0]  w_resNext;
    logic              w_lastBit;
    logic              w_ovfNext;

    // One ripple cell: borrow chain for subtract, carry chain for add; r_br holds whichever is active.
    always_comb begin
        w_dBit    = r_sa[0] ^ r_sb[0] ^ r_br;
        w_brNext  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
        w_ovfNext = (r_aMsb != r_bMsb) && (w_dBit != r_aMsb);
        if (r_isAdd) begin
            w_brNext  = (r_sa[0] & r_sb[0]) | ((r_sa[0] ^ r_sb[0]) & r_br);
            w_ovfNext = (r_aMsb == r_bMsb) && (w_dBit != r_aMsb);
        end
        w_resNext = {w_dBit, r_res};
        w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start)     w_stateNext = RUN;
            RUN:     if (w_lastBit) w_stateNext = DONE;
            DONE:    if (ack)       w_stateNext = IDLE;
            default:                w_stateNext = IDLE;
        endcase
    end

    // Operands are captured on acceptance, so a/b may change freely while the operation runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_aMsb   <= 1'b0;
            r_bMsb   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_isAdd  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_aMsb  <= a[WIDTH-1];
                        r_bMsb  <= b[WIDTH-1];
`ifdef SERIAL_SUBTRACTOR_ADD_EN
                        r_isAdd <= op;
`else
                        r_isAdd <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= w_resNext[WIDTH-1:1];
                    r_br  <= w_brNext;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_lastBit) begin
                        r_diff   <= w_resNext;
                        r_borrow <= w_brNext;
                        r_zero   <= (w_resNext == '0);
                        r_ovf    <= w_ovfNext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign valid  = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;
    assign ovf    = r_ovf;

endmodule
